// File: rtl/e203_cg_sched.sv
// Clock-gate scheduler: per-domain hold counters plus a RUN/DRAIN/SLEEP/WAKE sleep FSM.
// Define E203_CG_TCM_LS_EN to generate the registered TCM light-sleep requests.
module e203_cg_sched #(
  parameter int HOLD_CYC = 3,
  parameter int WAKE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic core_cgstop,
  input  logic ifu_active,
  input  logic exu_active,
  input  logic lsu_active,
  input  logic biu_active,
  input  logic itcm_active,
  input  logic dtcm_active,
  input  logic wfi_req,
  input  logic wake_evt,
  output logic ifu_clk_en,
  output logic exu_clk_en,
  output logic lsu_clk_en,
  output logic biu_clk_en,
  output logic itcm_clk_en,
  output logic dtcm_clk_en,
  output logic itcm_ls,
  output logic dtcm_ls,
  output logic wfi_ack,
  output logic core_sleeping
);

  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_CYC);
  localparam logic [3:0] WAKE_LEN = 4'(WAKE_CYC);

  state_t          state_q, state_d;
  logic [3:0]      wake_cnt_q, wake_cnt_d;
  logic            ack_d;
  logic [5:0]      act, hold_nz, dom_en;
  logic [5:0][3:0] hold_cnt;
  logic            drain_idle;

  // domain order: 0 ifu, 1 exu, 2 lsu, 3 biu, 4 itcm, 5 dtcm
  assign act = {dtcm_active, itcm_active, biu_active, lsu_active, exu_active, ifu_active};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst)                 hold_cnt[i] <= '0;
      else if (act[i])         hold_cnt[i] <= HOLD;
      else if (hold_nz[i])     hold_cnt[i] <= hold_cnt[i] - 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hold_nz[i] = |hold_cnt[i];
      dom_en[i]  = core_cgstop | act[i] | hold_nz[i];
    end
  end

  assign drain_idle = ~|(act[3:1] | hold_nz[3:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    ack_d      = 1'b0;
    case (state_q)
      RUN:   if (wfi_req && !wake_evt) state_d = DRAIN;
      DRAIN: begin
        if (wake_evt || !wfi_req) state_d = RUN;
        else if (drain_idle) begin
          state_d = SLEEP;
          ack_d   = 1'b1;
        end
      end
      SLEEP: if (wake_evt) begin
        state_d    = WAKE;
        wake_cnt_d = WAKE_LEN;
      end
      WAKE: begin
        // last forced cycle when the counter reads 1
        wake_cnt_d = wake_cnt_q - 4'd1;
        if (wake_cnt_q <= 4'd1) begin
          state_d    = RUN;
          wake_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ifu_clk_en = dom_en[0];
    if (state_q == SLEEP)     ifu_clk_en = core_cgstop;
    else if (state_q == WAKE) ifu_clk_en = 1'b1;
    ifu_clk_en = ifu_clk_en | rst;
  end

  assign exu_clk_en    = rst | dom_en[1] | (state_q == WAKE);
  assign lsu_clk_en    = rst | dom_en[2];
  assign biu_clk_en    = rst | dom_en[3];
  assign itcm_clk_en   = rst | dom_en[4];
  assign dtcm_clk_en   = rst | dom_en[5];
  assign wfi_ack       = ack_d & ~rst;
  assign core_sleeping = (state_q == SLEEP) & ~rst;

`ifdef E203_CG_TCM_LS_EN
  logic [1:0] ls_q;
  always_ff @(posedge clk) begin
    if (rst) ls_q <= '0;
    else     ls_q <= ~{dtcm_clk_en, itcm_clk_en};
  end
  assign itcm_ls = ls_q[0] & ~itcm_active & ~rst;
  assign dtcm_ls = ls_q[1] & ~dtcm_active & ~rst;
`else
  assign itcm_ls = 1'b0;
  assign dtcm_ls = 1'b0;
`endif

endmodule
